// File: rtl/bkg_line_fetcher.sv
// bkg_line_fetcher
//   Streams one source row of a half-resolution background image from SRAM
//   into a pair of line buffers while the VGA controller is scanning, and
//   serves the 2x-upscaled pixel for the current (DrawX, DrawY) from them.
//   Source row r is held in bank r[0]; display line Y reads bank Y[1].
//
// Ports
//   Clk, Reset_h       clock, synchronous active-high reset
//   DrawX, DrawY       current VGA pixel column / scan line
//   sram_rd_data       SRAM read data, valid 2 cycles after its address
//   SRAM_ADDR          SRAM word address (BASE_ADDR while idle)
//   SRAM_*_N           active-low SRAM strobes (reads only, WE_N held high)
//   bkg_color          registered RGB565 pixel for the previous DrawX/DrawY
//   fetch_busy         row fetch in progress (FETCH or DRAIN)
//   fetch_overrun      sticky: a fetch was restarted before completing
//
// state | meaning
// IDLE  | no fetch in flight
// FETCH | one SRAM read per cycle, columns 0..SRC_W-1
// DRAIN | two cycles for the last reads to land in the line buffer
module bkg_line_fetcher #(
  parameter logic [19:0] BASE_ADDR = 20'h00000,
  parameter int          SRC_W     = 320,
  parameter int          SRC_H     = 240
) (
  input  logic        Clk,
  input  logic        Reset_h,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  input  logic [15:0] sram_rd_data,
  output logic [19:0] SRAM_ADDR,
  output logic        SRAM_CE_N,
  output logic        SRAM_OE_N,
  output logic        SRAM_UB_N,
  output logic        SRAM_LB_N,
  output logic        SRAM_WE_N,
  output logic [15:0] bkg_color,
  output logic        fetch_busy,
  output logic        fetch_overrun
);

  localparam int COL_W = (SRC_W > 1) ? $clog2(SRC_W) : 1;
  localparam int ROW_W = (SRC_H > 1) ? $clog2(SRC_H) : 1;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(SRC_W - 1);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

  state_t           state_q, state_d;
  logic [9:0]       dy_q;
  logic             start;
  logic [ROW_W-1:0] start_row, row_q;
  logic [COL_W-1:0] col_q;
  logic             drain_q;

  logic             s1_valid, s2_valid;
  logic [COL_W-1:0] s1_col, s2_col;
  logic             s1_bank, s2_bank;

  logic [15:0]      line0 [SRC_W];
  logic [15:0]      line1 [SRC_W];
  logic [COL_W-1:0] disp_col;
  logic [15:0]      disp_word;
  logic [19:0]      rd_addr;

  // Even display line Y shows source row Y>>1, so the next row is fetched
  // into the other bank while the current one is still being displayed.
  always_comb begin
    start     = 1'b0;
    start_row = '0;
    if (DrawY != dy_q) begin
      if (DrawY == 10'd524) begin
        start = 1'b1;
      end else if (DrawY < 10'd480 && !DrawY[0] &&
                   ({1'b0, DrawY[9:1]} < 10'(SRC_H - 1))) begin
        start     = 1'b1;
        start_row = ROW_W'({1'b0, DrawY[9:1]} + 10'd1);
      end
    end
  end

  assign rd_addr = BASE_ADDR + 20'(row_q) * 20'(SRC_W) + 20'(col_q);

  always_comb begin
    state_d    = state_q;
    SRAM_ADDR  = BASE_ADDR;
    SRAM_CE_N  = 1'b1;
    SRAM_OE_N  = 1'b1;
    SRAM_UB_N  = 1'b1;
    SRAM_LB_N  = 1'b1;
    SRAM_WE_N  = 1'b1;
    fetch_busy = 1'b0;
    case (state_q)
      IDLE: ;
      FETCH: begin
        if (col_q == COL_LAST) state_d = DRAIN;
        SRAM_ADDR  = rd_addr;
        SRAM_CE_N  = 1'b0;
        SRAM_OE_N  = 1'b0;
        SRAM_UB_N  = 1'b0;
        SRAM_LB_N  = 1'b0;
        fetch_busy = 1'b1;
      end
      DRAIN: begin
        if (drain_q) state_d = IDLE;
        fetch_busy = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    // A new start pre-empts whatever is in flight
    if (start) state_d = FETCH;
  end

  always_comb begin
    disp_col  = COL_W'(DrawX[9:1]);
    disp_word = 16'h0000;
    if (DrawX < 10'd640 && DrawY < 10'd480 && ({1'b0, DrawX[9:1]} < 10'(SRC_W)))
      disp_word = DrawY[1] ? line1[disp_col] : line0[disp_col];
  end

  always_ff @(posedge Clk) begin
    if (Reset_h) begin
      state_q       <= IDLE;
      dy_q          <= 10'd0;
      row_q         <= '0;
      col_q         <= '0;
      drain_q       <= 1'b0;
      s1_valid      <= 1'b0;
      s2_valid      <= 1'b0;
      s1_col        <= '0;
      s2_col        <= '0;
      s1_bank       <= 1'b0;
      s2_bank       <= 1'b0;
      fetch_overrun <= 1'b0;
      bkg_color     <= 16'h0000;
    end else begin
      state_q <= state_d;
      dy_q    <= DrawY;
      if (start) begin
        row_q <= start_row;
        col_q <= '0;
        if (state_q != IDLE) fetch_overrun <= 1'b1;
      end else if (state_q == FETCH) begin
        col_q <= col_q + 1'b1;
      end
      // Low on the first DRAIN cycle, high on the second
      drain_q   <= (state_q == DRAIN);
      // Return pipeline mirrors the 2-cycle SRAM latency; a restart drops it
      s1_valid  <= (state_q == FETCH) && !start;
      s1_col    <= col_q;
      s1_bank   <= row_q[0];
      s2_valid  <= s1_valid && !start;
      s2_col    <= s1_col;
      s2_bank   <= s1_bank;
      bkg_color <= disp_word;
    end
  end

  // Line buffers are deliberately not reset
  always_ff @(posedge Clk) begin
    if (!Reset_h && s2_valid && !start) begin
      if (s2_bank) line1[s2_col] <= sram_rd_data;
      else         line0[s2_col] <= sram_rd_data;
    end
  end

endmodule

// File: tb/tb_bkg_line_fetcher.sv
// tb_bkg_line_fetcher
//   Randomized self-checking bench: a 2-cycle-latency SRAM model returns a
//   seeded hash of the address; expected addresses, busy windows and line
//   buffer contents are derived from row/column arithmetic and a per-bank
//   record of which source row was last fully loaded.
module tb_bkg_line_fetcher;
  localparam logic [19:0] BASE = 20'h00000;
  localparam int W = 320;
  localparam int H = 240;

  logic        Clk = 1'b0;
  logic        Reset_h;
  logic [9:0]  DrawX, DrawY;
  logic [15:0] sram_rd_data = 16'h0000;
  logic [19:0] SRAM_ADDR;
  logic        SRAM_CE_N, SRAM_OE_N, SRAM_UB_N, SRAM_LB_N, SRAM_WE_N;
  logic [15:0] bkg_color;
  logic        fetch_busy, fetch_overrun;

  int errors = 0;
  int checks = 0;
  int unsigned seed;
  int bank_row [2];

  logic [19:0] a1 = '0, a2 = '0;
  logic        v1 = 1'b0, v2 = 1'b0;

  bkg_line_fetcher #(.BASE_ADDR(BASE), .SRC_W(W), .SRC_H(H)) dut (
    .Clk(Clk), .Reset_h(Reset_h), .DrawX(DrawX), .DrawY(DrawY),
    .sram_rd_data(sram_rd_data), .SRAM_ADDR(SRAM_ADDR),
    .SRAM_CE_N(SRAM_CE_N), .SRAM_OE_N(SRAM_OE_N), .SRAM_UB_N(SRAM_UB_N),
    .SRAM_LB_N(SRAM_LB_N), .SRAM_WE_N(SRAM_WE_N), .bkg_color(bkg_color),
    .fetch_busy(fetch_busy), .fetch_overrun(fetch_overrun)
  );

  always #5 Clk = ~Clk;

  function automatic logic [15:0] mem_word(input logic [19:0] a);
    logic [31:0] t;
    t = 32'(a) * 32'h0000_9E37 + seed;
    return t[23:8];
  endfunction

  function automatic logic [19:0] exp_addr(input int row, input int col);
    logic [31:0] t;
    t = 32'(BASE) + 32'(row * W + col);
    return t[19:0];
  endfunction

  // SRAM: address seen in cycle c is answered from mid-cycle c+2
  always @(negedge Clk) begin
    sram_rd_data = v2 ? mem_word(a2) : (16'hBAD0 ^ 16'($urandom));
    a2 = a1;
    v2 = v1;
    a1 = SRAM_ADDR;
    v1 = !SRAM_CE_N && !SRAM_OE_N;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "timeout");
  end

  task automatic check_idle_outputs(input string name);
    checks++;
    if (SRAM_ADDR !== BASE || {SRAM_CE_N, SRAM_OE_N, SRAM_UB_N, SRAM_LB_N, SRAM_WE_N} !== 5'b11111) begin
      errors++;
      $display("FAIL %s sram: addr=%h strobes=%b, expected addr=%h strobes=11111", name, SRAM_ADDR,
               {SRAM_CE_N, SRAM_OE_N, SRAM_UB_N, SRAM_LB_N, SRAM_WE_N}, BASE);
    end
    checks++;
    if (fetch_busy !== 1'b0) begin
      errors++;
      $display("FAIL %s busy: got %b expected 0", name, fetch_busy);
    end
  endtask

  // Called right after the starting DrawY was driven at a falling edge
  task automatic watch_fetch(input int row, input string name);
    int busy_cnt = 0, addr_err = 0, strobe_err = 0, bad_n = -1;
    logic [19:0] bad_a = '0, bad_e = '0;
    for (int n = 1; n <= W + 6; n++) begin
      @(negedge Clk);
      if (fetch_busy === 1'b1) busy_cnt++;
      if (n <= W) begin
        if (SRAM_ADDR !== exp_addr(row, n - 1) ||
            {SRAM_CE_N, SRAM_OE_N, SRAM_UB_N, SRAM_LB_N} !== 4'b0000) begin
          addr_err++;
          if (bad_n < 0) begin
            bad_n = n; bad_a = SRAM_ADDR; bad_e = exp_addr(row, n - 1);
          end
        end
      end else if ({SRAM_CE_N, SRAM_OE_N, SRAM_UB_N, SRAM_LB_N} !== 4'b1111) begin
        strobe_err++;
      end
      if (SRAM_WE_N !== 1'b1) strobe_err++;
    end
    checks++;
    if (addr_err != 0) begin
      errors++;
      $display("FAIL %s addr: %0d bad cycles, first cycle %0d got %h expected %h", name, addr_err, bad_n, bad_a, bad_e);
    end
    checks++;
    if (busy_cnt != W + 2) begin
      errors++;
      $display("FAIL %s busy_len: got %0d expected %0d", name, busy_cnt, W + 2);
    end
    checks++;
    if (strobe_err != 0) begin
      errors++;
      $display("FAIL %s strobes: %0d cycles with wrong strobes, expected 0", name, strobe_err);
    end
    bank_row[row % 2] = row;
  endtask

  // Read back ncols columns of a bank through the display path (all if ncols==W)
  task automatic check_bank(input int bank, input int ncols, input string name);
    int errs = 0, col, bad_col = -1;
    logic [15:0] exp, bad_got = '0, bad_exp = '0;
    DrawY = (bank != 0) ? 10'd3 : 10'd1;
    col = (ncols == W) ? 0 : $urandom_range(0, W - 1);
    DrawX = 10'(2 * col + $urandom_range(0, 1));
    for (int k = 0; k < ncols; k++) begin
      @(negedge Clk);
      exp = mem_word(exp_addr(bank_row[bank], col));
      if (bkg_color !== exp) begin
        errs++;
        if (bad_col < 0) begin
          bad_col = col; bad_got = bkg_color; bad_exp = exp;
        end
      end
      col = (ncols == W) ? k + 1 : $urandom_range(0, W - 1);
      DrawX = 10'(2 * col + $urandom_range(0, 1));
    end
    checks++;
    if (errs != 0) begin
      errors++;
      $display("FAIL %s: %0d bad words, first col %0d got %h expected %h", name, errs, bad_col, bad_got, bad_exp);
    end
  endtask

  task automatic test_reset();
    logic seen = 1'b0;
    Reset_h = 1'b1; DrawX = 10'd0; DrawY = 10'd0;
    repeat (3) @(negedge Clk);
    check_idle_outputs("reset");
    checks++;
    if (fetch_overrun !== 1'b0 || bkg_color !== 16'h0000) begin
      errors++;
      $display("FAIL reset flags: overrun=%b color=%h expected 0/0000", fetch_overrun, bkg_color);
    end
    Reset_h = 1'b0;
    repeat (5) begin
      @(negedge Clk);
      seen |= (fetch_busy !== 1'b0) | (SRAM_CE_N !== 1'b1);
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL reset_no_fetch: activity=%b expected 0", seen);
    end
  endtask

  task automatic test_frame_start();
    DrawY = 10'd523;
    repeat (2) @(negedge Clk);
    check_idle_outputs("line523");
    DrawY = 10'd524;
    watch_fetch(0, "row0");
    check_bank(0, W, "bank0_row0");
  endtask

  task automatic test_row6();
    DrawY = 10'd9;
    @(negedge Clk);
    DrawY = 10'd10;
    watch_fetch(6, "row6");
    check_bank(0, 40, "bank0_row6");
  endtask

  task automatic test_display();
    int n = 0;
    DrawY = 10'd11; DrawX = 10'd0;
    @(negedge Clk);
    DrawY = 10'd12; DrawX = 10'd7;
    @(negedge Clk);
    checks++;
    if (bkg_color !== mem_word(exp_addr(6, 3))) begin
      errors++;
      $display("FAIL disp_12_7: got %h expected %h", bkg_color, mem_word(exp_addr(6, 3)));
    end
    DrawX = 10'd700;
    @(negedge Clk);
    checks++;
    if (bkg_color !== 16'h0000) begin
      errors++;
      $display("FAIL disp_x700: got %h expected 0000", bkg_color);
    end
    while (fetch_busy === 1'b1 && n < 400) begin
      @(negedge Clk);
      n++;
    end
    checks++;
    if (n >= 400) begin
      errors++;
      $display("FAIL row7_done: busy after %0d cycles, expected idle", n);
    end
    bank_row[1] = 7;
    DrawY = 10'd481; DrawX = 10'd10;
    @(negedge Clk);
    checks++;
    if (bkg_color !== 16'h0000 || fetch_busy !== 1'b0) begin
      errors++;
      $display("FAIL disp_y481: color=%h busy=%b expected 0000/0", bkg_color, fetch_busy);
    end
    check_bank(1, 40, "bank1_row7");
  endtask

  task automatic test_no_fetch();
    logic seen = 1'b0;
    DrawY = 10'd477;
    @(negedge Clk);
    DrawY = 10'd478;
    repeat (10) begin
      @(negedge Clk);
      seen |= (fetch_busy !== 1'b0) |
              ({SRAM_CE_N, SRAM_OE_N, SRAM_UB_N, SRAM_LB_N, SRAM_WE_N} !== 5'b11111);
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL line478: activity=%b expected 0", seen);
    end
    checks++;
    if (fetch_overrun !== 1'b0) begin
      errors++;
      $display("FAIL overrun_clear: got %b expected 0", fetch_overrun);
    end
  endtask

  task automatic test_overrun();
    DrawY = 10'd20;
    repeat (101) @(negedge Clk);
    checks++;
    if (SRAM_ADDR !== exp_addr(11, 100) || fetch_overrun !== 1'b0) begin
      errors++;
      $display("FAIL row11_col100: addr=%h overrun=%b expected %h/0", SRAM_ADDR, fetch_overrun, exp_addr(11, 100));
    end
    DrawY = 10'd22;
    watch_fetch(12, "restart_row12");
    bank_row[1] = -1;
    checks++;
    if (fetch_overrun !== 1'b1) begin
      errors++;
      $display("FAIL overrun_set: got %b expected 1", fetch_overrun);
    end
    check_bank(0, W, "bank0_row12");
    DrawY = 10'd40;
    watch_fetch(21, "row21");
    checks++;
    if (fetch_overrun !== 1'b1) begin
      errors++;
      $display("FAIL overrun_sticky: got %b expected 1", fetch_overrun);
    end
  endtask

  task automatic test_reset_mid();
    logic seen = 1'b0;
    DrawY = 10'd42; DrawX = 10'd11;
    repeat (51) @(negedge Clk);
    checks++;
    if (SRAM_ADDR !== exp_addr(22, 50)) begin
      errors++;
      $display("FAIL row22_col50: got %h expected %h", SRAM_ADDR, exp_addr(22, 50));
    end
    Reset_h = 1'b1; DrawY = 10'd0;
    @(negedge Clk);
    check_idle_outputs("reset_mid");
    checks++;
    if (bkg_color !== 16'h0000 || fetch_overrun !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid flags: color=%h overrun=%b expected 0000/0", bkg_color, fetch_overrun);
    end
    Reset_h = 1'b0;
    repeat (4) begin
      @(negedge Clk);
      seen |= (fetch_busy !== 1'b0);
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_idle: busy seen=%b expected 0", seen);
    end
    bank_row[0] = -1;
    check_bank(1, W, "bank1_retained");
  endtask

  task automatic test_random();
    int y, row;
    for (int i = 0; i < 4; i++) begin
      y = 2 * $urandom_range(0, 238);
      row = y / 2 + 1;
      DrawY = 10'(y);
      watch_fetch(row, "rand_fetch");
      check_bank(row % 2, 24, "rand_bank");
      DrawX = 10'($urandom_range(640, 1023));
      @(negedge Clk);
      checks++;
      if (bkg_color !== 16'h0000) begin
        errors++;
        $display("FAIL rand_x_oob: x=%0d got %h expected 0000", DrawX, bkg_color);
      end
    end
    checks++;
    if (fetch_overrun !== 1'b0) begin
      errors++;
      $display("FAIL rand_overrun: got %b expected 0", fetch_overrun);
    end
  endtask

  initial begin
    seed = $urandom;
    bank_row[0] = -1;
    bank_row[1] = -1;
    test_reset();
    test_frame_start();
    test_row6();
    test_display();
    test_no_fetch();
    test_overrun();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/bkg_line_fetcher.md
BKG_LINE_FETCHER -- requirements
Module: bkg_line_fetcher

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 20'h00000: SRAM word address of background row 0, column 0.
REQ-002 SHALL have parameter SRC_W, default 320: source image width in words (pixels).
REQ-003 SHALL have parameter SRC_H, default 240: source image height in rows.
REQ-004 SHALL have port Clk, input, 1: the single clock; all state updates on rising edge.
REQ-005 SHALL have port Reset_h, input, 1: reset, synchronous, active-high.
REQ-006 SHALL have port DrawX, input, 10: current pixel column from the VGA controller.
REQ-007 SHALL have port DrawY, input, 10: current scan line from the VGA controller, 0..524.
REQ-008 SHALL have port sram_rd_data, input, 16: SRAM read data, valid exactly 2 Clk cycles after its address is driven.
REQ-009 SHALL have port SRAM_ADDR, output, 20: SRAM word address.
REQ-010 SHALL have ports SRAM_CE_N, SRAM_OE_N, SRAM_UB_N, SRAM_LB_N, SRAM_WE_N, output, 1 each: active-low SRAM strobes.
REQ-011 SHALL have port bkg_color, output, 16: RGB565 background pixel for (DrawX, DrawY).
REQ-012 SHALL have port fetch_busy, output, 1: high while a row fetch is in progress.
REQ-013 SHALL have port fetch_overrun, output, 1: sticky flag, a fetch was restarted before it completed.

Function
REQ-014 SHALL hold two line buffers (bank 0, bank 1), each SRC_W x 16 bits; source row r lives in bank r[0].
REQ-015 SHALL register DrawY each cycle and detect a new line when DrawY differs from its registered value.
REQ-016 On new line Y == 524, SHALL start a fetch of source row 0.
REQ-017 On new line Y < 480 with Y[0] == 0 and (Y>>1) < SRC_H-1, SHALL start a fetch of source row (Y>>1)+1; otherwise no fetch.
REQ-018 FSM states: IDLE, FETCH, DRAIN.
- IDLE -> FETCH on start.
- FETCH issues one read per cycle for columns 0..SRC_W-1, then -> DRAIN.
- DRAIN waits 2 cycles for the last returns, then -> IDLE.
REQ-019 Address SHALL be BASE_ADDR + row*SRC_W + col, computed in 20 bits; overflow wraps modulo 2^20.
REQ-020 SHALL write each returned word to buffer bank row[0] at its column, tracked via a 2-stage valid/column/bank pipeline aligned to the read latency.
REQ-021 In FETCH: SRAM_CE_N, SRAM_OE_N, SRAM_UB_N and SRAM_LB_N SHALL be 0; otherwise 1.
REQ-022 SRAM_WE_N SHALL be 1 at all times.
REQ-023 fetch_busy SHALL be 1 in FETCH and DRAIN, 0 in IDLE.
REQ-024 A start arriving in FETCH or DRAIN SHALL:
- abort the current fetch;
- flush the pending pipeline writes;
- restart at column 0 of the new row;
- set fetch_overrun, which stays 1 until reset.
REQ-025 bkg_color SHALL be registered (1-cycle latency from DrawX/DrawY): bank DrawY[1], column DrawX>>1 when DrawX < 640 and DrawY < 480; 16'h0000 otherwise.
REQ-026 A buffer write and a display read of the same bank/column in the same cycle SHALL return the old contents; this cannot occur in legal operation per REQ-014/017.

Reset
REQ-027 Reset_h high at a rising edge SHALL, regardless of FSM state:
- force IDLE and invalidate the read pipeline;
- set bkg_color = 0, fetch_busy = 0, fetch_overrun = 0;
- drive SRAM_ADDR = BASE_ADDR and all SRAM strobes = 1.
REQ-028 Line buffer contents SHALL NOT be cleared by reset.
REQ-029 After reset, the registered DrawY SHALL be 10'd0; no fetch starts until a new-line event occurs.

Verification
REQ-030 DrawY 523 -> 524 -> fetch row 0: SRAM_ADDR 0..319 on consecutive cycles; fetch_busy high 322 cycles; bank 0 word k == model[k].
REQ-031 DrawY 9 -> 10 -> fetch row 6: first SRAM_ADDR = BASE_ADDR+1920; data written to bank 0.
REQ-032 Display DrawY = 12, DrawX = 7 -> bkg_color = row 6, col 3 data one cycle later; DrawX = 700 -> 16'h0000.
REQ-033 DrawY = 478 -> no fetch; fetch_busy stays 0; SRAM strobes stay 1.
REQ-034 Force a new line at column 100 of a fetch -> restart at column 0 of the new row; fetch_overrun = 1 and stays 1.
REQ-035 Reset_h asserted during FETCH at column 50 -> next cycle IDLE, strobes = 1, fetch_busy = 0, bkg_color = 0.
